// File: rtl/booth_pp_gen_32.sv
// booth_pp_gen_32
//   Two-stage pipelined radix-4 Booth encoder and partial-product generator
//   for the 32x32 signed multiplier. Each accepted operand pair produces NPP
//   sign-extended, pre-shifted PW-bit rows. Summed mod 2^PW, they equal a*b.
//   Rows whose Booth digit is 0 are forced to 0 and flagged in pp_zero.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b sampled on accept)
//   a, b                 two's complement multiplicand / multiplier
//   out_valid/out_ready  row handshake
//   pp_flat              row k at [k*PW +: PW]
//   pp_zero              bit k set when row k's digit is 0

// booth_pp_row
//   Forms one row: (sext(a) * d) << 2K, with d in {0,+-1,+-2} given as
//   {neg, one, two}.
// Ports
//   a                    multiplicand
//   neg, one, two        decoded Booth digit
//   row                  shifted row, PW bits
module booth_pp_row #(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               neg,
    input  logic               one,
    input  logic               two,
    output logic [2*WIDTH-1:0] row
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] ax;
    logic [PW-1:0] mag;
    logic [PW-1:0] sgn;

    always_comb begin
        ax  = {{WIDTH{a[WIDTH-1]}}, a};
        mag = '0;
        // PW >= WIDTH+1, so doubling after sign extension cannot overflow.
        if (two)      mag = ax << 1;
        else if (one) mag = ax;
        // Full two's complement negation keeps every row self-contained.
        sgn = neg ? (~mag + PW'(1)) : mag;
        row = sgn << (2 * K);
    end
endmodule

module booth_pp_gen_32 #(
    parameter  int WIDTH = 32,
    localparam int NPP   = WIDTH / 2,
    localparam int PW    = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NPP*PW-1:0] pp_flat,
    output logic [NPP-1:0]    pp_zero
);
    // S1: registered multiplicand plus decoded digits
    logic                      s1_valid;
    logic [WIDTH-1:0]          a_s1;
    logic [NPP-1:0]            neg_s1, one_s1, two_s1;
    // S2: finished rows
    logic                      s2_valid;
    logic [NPP-1:0][PW-1:0]    rows_s2;
    logic [NPP-1:0]            zero_s2;
    // Low during reset; keeps in_ready low until the cycle after release.
    logic                      run;

    logic [WIDTH:0]            bx;
    logic [NPP-1:0]            neg_d, one_d, two_d;
    logic [NPP-1:0][PW-1:0]    rows_d;
    logic                      s2_free, adv1, adv2, accept;

    assign s2_free  = ~s2_valid | out_ready;
    assign adv2     = s2_valid & out_ready;
    assign adv1     = s1_valid & s2_free;
    assign in_ready = run & rst_n & (~s1_valid | s2_free);
    assign accept   = in_valid & in_ready;

    // Booth triplet {b[2k+1], b[2k], b[2k-1]} with b[-1] = 0.
    // 111 is a zero digit, so neg is suppressed for it.
    always_comb begin
        bx = {b, 1'b0};
        neg_d = '0;
        one_d = '0;
        two_d = '0;
        for (int k = 0; k < NPP; k++) begin
            neg_d[k] = bx[2*k+2] & ~(bx[2*k+1] & bx[2*k]);
            one_d[k] = bx[2*k+1] ^ bx[2*k];
            two_d[k] = (bx[2*k+2] & ~bx[2*k+1] & ~bx[2*k]) |
                       (~bx[2*k+2] & bx[2*k+1] & bx[2*k]);
        end
    end

    for (genvar k = 0; k < NPP; k++) begin : g_row
        booth_pp_row #(.WIDTH(WIDTH), .K(k)) u_row (
            .a   (a_s1),
            .neg (neg_s1[k]),
            .one (one_s1[k]),
            .two (two_s1[k]),
            .row (rows_d[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            a_s1     <= '0;
            neg_s1   <= '0;
            one_s1   <= '0;
            two_s1   <= '0;
            rows_s2  <= '0;
            zero_s2  <= '1;
        end else begin
            run <= 1'b1;
            if (accept)    s1_valid <= 1'b1;
            else if (adv1) s1_valid <= 1'b0;
            if (adv1)      s2_valid <= 1'b1;
            else if (adv2) s2_valid <= 1'b0;
            // Data registers load only when their stage takes a new entry.
            if (accept) begin
                a_s1   <= a;
                neg_s1 <= neg_d;
                one_s1 <= one_d;
                two_s1 <= two_d;
            end
            if (adv1) begin
                rows_s2 <= rows_d;
                zero_s2 <= ~(one_s1 | two_s1);
            end
        end
    end

    // Stale S2 contents never leak: idle outputs read as all-zero rows.
    assign out_valid = s2_valid;
    assign pp_flat   = s2_valid ? rows_s2 : '0;
    assign pp_zero   = s2_valid ? zero_s2 : '1;
endmodule

// File: tb/tb_booth_pp_gen_32.sv
module tb_booth_pp_gen_32;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [31:0]   a, b;
    logic          out_valid, out_ready;
    logic [1023:0] pp_flat;
    logic [15:0]   pp_zero;

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;
    logic [63:0] q[$];

    booth_pp_gen_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .pp_flat(pp_flat), .pp_zero(pp_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: digit value straight from the Booth rule, row by multiplication.
    function automatic int digit(input logic [31:0] bv, input int k);
        logic [32:0] bb;
        bb = {bv, 1'b0};
        return (bb[2*k+1] ? 1 : 0) + (bb[2*k] ? 1 : 0) - (bb[2*k+2] ? 2 : 0);
    endfunction

    function automatic logic [63:0] ref_row(input logic [31:0] av, input logic [31:0] bv, input int k);
        longint p;
        p = longint'($signed(av)) * longint'(digit(bv, k));
        return 64'(p) << (2 * k);
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] r, input int k);
        return (k == 0) ? r : ((r << k) | (r >> (64 - k)));
    endfunction

    function automatic logic [63:0] dut_row(input int k);
        return pp_flat[k*64 +: 64];
    endfunction

    function automatic logic [63:0] dut_sum();
        logic [63:0] s = '0;
        for (int k = 0; k < 16; k++) s += dut_row(k);
        return s;
    endfunction

    function automatic logic [63:0] dut_fold();
        logic [63:0] f = '0;
        for (int k = 0; k < 16; k++) f ^= rot(dut_row(k), k);
        return f;
    endfunction

    task automatic check_beat(input logic [63:0] pr);
        logic [31:0] av, bv;
        logic [63:0] f;
        logic [15:0] z;
        longint prod;
        av = pr[63:32];
        bv = pr[31:0];
        f = '0;
        z = '0;
        for (int k = 0; k < 16; k++) begin
            f ^= rot(ref_row(av, bv, k), k);
            z[k] = (digit(bv, k) == 0);
        end
        prod = longint'($signed(av)) * longint'($signed(bv));
        chk("sum", dut_sum(), 64'(prod));
        chk("zero", {48'b0, pp_zero}, {48'b0, z});
        chk("rows", dut_fold(), f);
    endtask

    // Scoreboard: accepted pairs queued in order, every output beat popped.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                beats++;
                if (q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
                else check_beat(q.pop_front());
            end else if (!out_valid) begin
                chk("idle_zero", {48'b0, pp_zero}, 64'hFFFF);
                chk("idle_flat", {63'b0, |pp_flat}, 64'd0);
            end
            if (in_valid && in_ready) q.push_back({a, b});
        end
    end

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Single pair through an empty pipeline with out_ready=1; checks latency.
    task automatic one_shot(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] exp_sum);
        tick();
        out_ready = 1'b1;
        a = av; b = bv; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_acc"}, {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk({tag, "_lat2"}, {63'b0, out_valid}, 64'd1);
        chk({tag, "_sum"}, dut_sum(), exp_sum);
    endtask

    logic [31:0] pa[4] = '{32'd7, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] pb[4] = '{32'd9, 32'h0000_0101, 32'hCAFE_F00D, 32'h7FFF_FFFF};

    initial begin
        int acc, idx, b0, cnt, cyc;
        logic took, have;
        logic [63:0] f0;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_zero", {48'b0, pp_zero}, 64'hFFFF);
        chk("rst_flat", {63'b0, |pp_flat}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("ready_after_rst", {63'b0, in_ready}, 64'd1);

        // T1..T3 directed
        one_shot("t1", 32'd3, 32'd5, 64'd15);
        chk("t1_row0", dut_row(0), 64'd3);
        chk("t1_row1", dut_row(1), 64'd12);
        chk("t1_pzero", {48'b0, pp_zero}, 64'hFFFC);
        one_shot("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
        chk("t2_row0", dut_row(0), 64'h1);
        chk("t2_pzero", {48'b0, pp_zero}, 64'hFFFE);
        one_shot("t3a", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        one_shot("t3b", 32'h8000_0000, 32'h0000_0003, 64'hFFFF_FFFE_8000_0000);
        repeat (3) tick();

        // T4 backpressure
        out_ready = 1'b0;
        idx = 0; acc = 0; have = 1'b0; f0 = '0;
        a = pa[0]; b = pb[0]; in_valid = 1'b1;
        b0 = beats;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            if (out_valid) begin
                if (!have) begin have = 1'b1; f0 = dut_fold(); end
                else chk("t4_stable", dut_fold(), f0);
            end
            tick();
            if (took) begin idx++; a = pa[idx]; b = pb[idx]; end
        end
        @(negedge clk);
        chk("t4_accepts", 64'(acc), 64'd2);
        chk("t4_ready_low", {63'b0, in_ready}, 64'd0);
        chk("t4_held", {63'b0, out_valid}, 64'd1);
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
            if (took) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else begin a = pa[idx]; b = pb[idx]; end
            end
        end
        in_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("t4_all_sent", 64'(idx), 64'd4);
        chk("t4_beats", 64'(beats - b0), 64'd4);
        chk("t4_q_empty", 64'(q.size()), 64'd0);

        // T5 reset with two pairs in flight
        tick();
        out_ready = 1'b0;
        a = 32'd11; b = 32'd13; in_valid = 1'b1;
        tick();
        a = 32'd17; b = 32'd19;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_full", {63'b0, in_ready}, 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_valid", {63'b0, out_valid}, 64'd0);
        chk("t5_zero", {48'b0, pp_zero}, 64'hFFFF);
        chk("t5_flat", {63'b0, |pp_flat}, 64'd0);
        out_ready = 1'b1;
        b0 = beats;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            chk("t5_no_stale", {63'b0, out_valid}, 64'd0);
        end
        chk("t5_beats", 64'(beats - b0), 64'd0);

        // T6 random traffic
        cnt = 0; cyc = 0;
        tick();
        while (cnt < 10000 && cyc < 60000) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            a = rnd32();
            b = rnd32();
            @(negedge clk);
            if (in_valid && in_ready) cnt++;
            tick();
            cyc++;
        end
        chk("t6_count", 64'(cnt), 64'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t6_drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
